// File: rtl/jtag_host_if.sv
`default_nettype none
// ============================================================================
// jtag_host_if : command/response port of the bit-banged JTAG initiator
// Revision     : 1.0
// ============================================================================
interface jtag_host_if #(
    parameter int MAX_LEN = 64,
    parameter int LW      = $clog2(MAX_LEN) + 1
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LW-1:0]      cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/jtag_host.sv
`default_nettype none
// ============================================================================
// jtag_host : bit-banged JTAG initiator issuing TAP reset / IR / DR / idle ops
// Revision  : 1.0
// ============================================================================
module jtag_host #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 64,
    parameter int LW      = $clog2(MAX_LEN) + 1
) (
    input  wire         sysclk,
    input  wire         reset,
    jtag_host_if.slave  bus,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  wire         tdo,
    output logic        trst
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRST  = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_IDLE = 2'b11;

    logic [2:0]         r_state;
    logic [LW-1:0]      r_idx;
    logic [1:0]         r_op;
    logic [LW-1:0]      r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [DW-1:0]      r_div;
    logic               r_phase;
    logic               r_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_data;

    logic               w_accept;
    logic [LW-1:0]      w_len_in;
    logic [1:0]         w_op;
    logic [LW-1:0]      w_len;
    logic [MAX_LEN-1:0] w_data;
    logic               w_busy;
    logic               w_half_end;
    logic               w_period_end;
    logic [LW-1:0]      w_hdr_last;
    logic [2:0]         w_nstate;
    logic [LW-1:0]      w_nidx;
    logic               w_ntms;
    logic               w_ntdi;
    logic               w_ntrst;

    assign bus.cmd_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    assign w_accept     = r_ready & bus.cmd_valid;
    assign w_len_in     = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
    // On the accept edge the first period is set up from the incoming command
    assign w_op         = w_accept ? bus.cmd_op   : r_op;
    assign w_len        = w_accept ? w_len_in     : r_len;
    assign w_data       = w_accept ? bus.cmd_data : r_data;
    assign w_busy       = (r_state == S_TRST) || (r_state == S_PRE) ||
                          (r_state == S_SHIFT) || (r_state == S_POST);
    assign w_half_end   = (r_div == DIV_LAST);
    assign w_period_end = w_busy & w_half_end & r_phase;
    assign w_hdr_last   = (r_op == OP_IR) ? LW'(3) : LW'(2);

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx + LW'(1);
        if (w_accept) begin
            w_nidx = '0;
            if (bus.cmd_op == OP_RST)      w_nstate = S_TRST;
            else if (w_len_in == '0)       w_nstate = S_DONE;
            else if (bus.cmd_op == OP_IDLE) w_nstate = S_SHIFT;
            else                           w_nstate = S_PRE;
        end else begin
            case (r_state)
                S_TRST:  if (r_idx == LW'(6)) w_nstate = S_DONE;
                S_PRE:   if (r_idx == w_hdr_last) begin
                             w_nstate = S_SHIFT;
                             w_nidx   = '0;
                         end
                S_SHIFT: if (r_idx == r_len - LW'(1)) begin
                             w_nstate = (r_op == OP_IDLE) ? S_DONE : S_POST;
                             w_nidx   = '0;
                         end
                S_POST:  if (r_idx == LW'(1)) w_nstate = S_DONE;
                default: ;
            endcase
        end
    end

    // Pin values for the period about to start
    always_comb begin
        w_ntms  = tms;
        w_ntdi  = 1'b0;
        w_ntrst = 1'b0;
        case (w_nstate)
            S_TRST: begin
                w_ntrst = (w_nidx == '0);
                w_ntms  = (w_nidx != LW'(6));
            end
            S_PRE:   w_ntms = (w_op == OP_IR) ? (w_nidx < LW'(2)) : (w_nidx == '0);
            S_SHIFT: begin
                if (w_op == OP_IDLE) begin
                    w_ntms = 1'b0;
                end else begin
                    w_ntdi = w_data[w_nidx[IW-1:0]];
                    w_ntms = (w_nidx == w_len - LW'(1));
                end
            end
            S_POST:  w_ntms = (w_nidx == '0);
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_op        <= OP_RST;
            r_len       <= '0;
            r_data      <= '0;
            r_div       <= '0;
            r_phase     <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            trst        <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_ready    <= 1'b0;
                    r_op       <= bus.cmd_op;
                    r_len      <= w_len_in;
                    r_data     <= bus.cmd_data;
                    r_rsp_data <= '0;
                end else begin
                    r_ready <= 1'b1;
                    trst    <= 1'b0;
                end
            end
            if (r_state == S_DONE) begin
                r_rsp_valid <= 1'b1;
                r_ready     <= 1'b1;
            end
            if (w_accept || w_period_end || (r_state == S_DONE)) begin
                r_state <= (r_state == S_DONE) ? S_IDLE : w_nstate;
                r_idx   <= w_nidx;
                tms     <= w_ntms;
                tdi     <= w_ntdi;
                trst    <= w_ntrst;
                tck     <= 1'b0;
                r_div   <= '0;
                r_phase <= 1'b0;
            end else if (w_busy) begin
                if (w_half_end) begin
                    r_div   <= '0;
                    r_phase <= 1'b1;
                    // The TRST hold period keeps tck low throughout
                    tck     <= !((r_state == S_TRST) && (r_idx == '0));
                    if ((r_state == S_SHIFT) && (r_op != OP_IDLE))
                        r_rsp_data[r_idx[IW-1:0]] <= tdo;
                end else begin
                    r_div <= r_div + DW'(1);
                end
            end
        end
    end
endmodule
`default_nettype wire
